// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and constants for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // A divide-by-one prescaler still needs one register bit to exist.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_controller_bcd_digit.sv
// rtl/stopwatch_controller_bcd_digit.sv - single decade counter stage, wraps 9 -> 0
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       at_max
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/overflow sequencer, prescaler, decade cascade and lap freeze
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int DIGITS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                lap,
    input  logic                clear,
    output logic [4*DIGITS-1:0] digits,
    output logic                running,
    output logic                frozen,
    output logic                overflow,
    output logic                tick
);

    localparam int            PW         = presc_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t           state, state_nx;
    logic [PW-1:0]       presc, presc_nx;
    logic                frozen_nx;
    logic [4*DIGITS-1:0] count, snap, snap_nx;
    logic [DIGITS-1:0]   at_max, dig_en;
    logic [DIGITS:0]     low9;
    logic                inc, all9;

    assign inc     = (state == RUN) && (presc == PRESC_LAST);
    assign low9[0] = 1'b1;
    assign all9    = low9[DIGITS];

    // Stage k advances only when every lower stage is about to wrap; all-9s holds.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign low9[k+1] = low9[k] & at_max[k];
        assign dig_en[k] = inc && !all9 && !clear && low9[k];

        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .en     (dig_en[k]),
            .clr    (clear),
            .q      (count[4*k +: 4]),
            .at_max (at_max[k])
        );
    end

    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        frozen_nx = frozen;
        snap_nx   = snap;
        if (clear) begin
            state_nx  = IDLE;
            presc_nx  = '0;
            frozen_nx = 1'b0;
            snap_nx   = '0;
        end else begin
            if (state == RUN) begin
                presc_nx = inc ? '0 : presc + 1'b1;
            end
            // Overflow wins over a coincident button so the saturated count is shown.
            if (inc && all9) begin
                state_nx  = OVF;
                frozen_nx = 1'b0;
            end else if (start_stop) begin
                case (state)
                    IDLE:    state_nx = RUN;
                    RUN:     state_nx = PAUSE;
                    PAUSE:   state_nx = RUN;
                    default: state_nx = state;
                endcase
            end else if (lap && (state == RUN || state == PAUSE)) begin
                if (frozen) begin
                    frozen_nx = 1'b0;
                end else begin
                    frozen_nx = 1'b1;
                    snap_nx   = count;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            presc  <= '0;
            frozen <= 1'b0;
            snap   <= '0;
            tick   <= 1'b0;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            frozen <= frozen_nx;
            snap   <= snap_nx;
            tick   <= inc && !clear;
        end
    end

    assign digits   = frozen ? snap : count;
    assign running  = (state == RUN);
    assign overflow = (state == OVF);

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - randomized and directed bench against an integer-valued stopwatch model
module tb_stopwatch_controller;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;
    localparam int MAXV   = 9999;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ss_a = 1'b0, lp_a = 1'b0, cl_a = 1'b0;
    logic ss_b = 1'b0, lp_b = 1'b0, cl_b = 1'b0;
    logic [15:0] dg_a, dg_b;
    logic run_a, frz_a, ovf_a, tick_a;
    logic run_b, frz_b, ovf_b, tick_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_state [2];
    int m_presc [2];
    int m_count [2];
    int m_snap  [2];
    bit m_frozen[2];
    bit m_tick  [2];
    int div     [2];

    always #5 clk = ~clk;

    stopwatch_controller #(.TICK_DIV(4), .DIGITS(4)) dut_a (
        .clk(clk), .reset(reset), .start_stop(ss_a), .lap(lp_a), .clear(cl_a),
        .digits(dg_a), .running(run_a), .frozen(frz_a), .overflow(ovf_a), .tick(tick_a)
    );

    stopwatch_controller #(.TICK_DIV(1), .DIGITS(4)) dut_b (
        .clk(clk), .reset(reset), .start_stop(ss_b), .lap(lp_b), .clear(cl_b),
        .digits(dg_b), .running(run_b), .frozen(frz_b), .overflow(ovf_b), .tick(tick_b)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE; m_presc[i] = 0; m_count[i] = 0;
            m_snap[i] = 0; m_frozen[i] = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ss, input bit lp, input bit cl);
        int  pre_count;
        bit  inc;
        bit  ovf_now;
        if (cl) begin
            m_state[i] = M_IDLE; m_presc[i] = 0; m_count[i] = 0;
            m_snap[i] = 0; m_frozen[i] = 1'b0; m_tick[i] = 1'b0;
            return;
        end
        pre_count = m_count[i];
        inc = (m_state[i] == M_RUN) && (m_presc[i] == div[i] - 1);
        m_tick[i] = inc;
        ovf_now = 1'b0;
        if (m_state[i] == M_RUN) m_presc[i] = inc ? 0 : m_presc[i] + 1;
        if (inc) begin
            if (m_count[i] == MAXV) ovf_now = 1'b1;
            else m_count[i] = m_count[i] + 1;
        end
        if (ovf_now) begin
            m_state[i] = M_OVF;
            m_frozen[i] = 1'b0;
        end else if (ss) begin
            if (m_state[i] == M_IDLE || m_state[i] == M_PAUSE) m_state[i] = M_RUN;
            else if (m_state[i] == M_RUN) m_state[i] = M_PAUSE;
        end else if (lp && (m_state[i] == M_RUN || m_state[i] == M_PAUSE)) begin
            if (m_frozen[i]) m_frozen[i] = 1'b0;
            else begin
                m_frozen[i] = 1'b1;
                m_snap[i] = pre_count;
            end
        end
    endtask

    task automatic cycle2(input bit sa, input bit la, input bit ca,
                          input bit sb, input bit lb, input bit cb);
        ss_a = sa; lp_a = la; cl_a = ca;
        ss_b = sb; lp_b = lb; cl_b = cb;
        @(posedge clk);
        model_step(0, sa, la, ca);
        model_step(1, sb, lb, cb);
        #1;
        ss_a = 1'b0; lp_a = 1'b0; cl_a = 1'b0;
        ss_b = 1'b0; lp_b = 1'b0; cl_b = 1'b0;
    endtask

    task automatic cyc(input int i, input bit ss, input bit lp, input bit cl);
        if (i == 0) cycle2(ss, lp, cl, 1'b0, 1'b0, 1'b0);
        else        cycle2(1'b0, 1'b0, 1'b0, ss, lp, cl);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_digits",   {16'd0, dg_a}, {16'd0, to_bcd(m_frozen[0] ? m_snap[0] : m_count[0])});
            check("a_running",  {31'd0, run_a},  {31'd0, m_state[0] == M_RUN});
            check("a_overflow", {31'd0, ovf_a},  {31'd0, m_state[0] == M_OVF});
            check("a_frozen",   {31'd0, frz_a},  {31'd0, m_frozen[0]});
            check("a_tick",     {31'd0, tick_a}, {31'd0, m_tick[0]});
            check("b_digits",   {16'd0, dg_b}, {16'd0, to_bcd(m_frozen[1] ? m_snap[1] : m_count[1])});
            check("b_running",  {31'd0, run_b},  {31'd0, m_state[1] == M_RUN});
            check("b_overflow", {31'd0, ovf_b},  {31'd0, m_state[1] == M_OVF});
            check("b_frozen",   {31'd0, frz_b},  {31'd0, m_frozen[1]});
            check("b_tick",     {31'd0, tick_b}, {31'd0, m_tick[1]});
        end
    end

    initial begin
        int nt;
        int last;
        div[0] = 4;
        div[1] = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        check("rst_digits", {16'd0, dg_a}, 32'h0);

        // basic run, divide by 4
        cyc(0, 1, 0, 0);
        nt = 0;
        last = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc(0, 0, 0, 0);
            if (tick_a) begin
                if (nt > 0) check("tick_gap", c - last, 4);
                last = c;
                nt++;
            end
        end
        check("tick_count", nt, 10);
        check("basic_digits", {16'd0, dg_a}, 32'h0010);
        check("basic_running", {31'd0, run_a}, 32'd1);
        check("model_basic", m_count[0], 10);

        // asynchronous reset while running and frozen
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("arst_digits", {16'd0, dg_a}, 32'h0);
        check("arst_running", {31'd0, run_a}, 32'd0);
        check("arst_frozen", {31'd0, frz_a}, 32'd0);
        check("arst_overflow", {31'd0, ovf_a}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // pause retains the partial prescaler period
        cyc(0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("pause_running", {31'd0, run_a}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            cyc(0, 0, 0, 0);
            check("pause_hold", {16'd0, dg_a}, 32'h0001);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("resume_t1", {31'd0, tick_a}, 32'd0);
        cyc(0, 0, 0, 0);
        check("resume_t2", {31'd0, tick_a}, 32'd1);
        check("resume_digits", {16'd0, dg_a}, 32'h0002);
        cyc(0, 0, 0, 1);

        // overflow, divide by 1, with a freeze that overflow must release
        cyc(1, 1, 0, 0);
        repeat (9990) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        check("ovf_frozen_pre", {31'd0, frz_b}, 32'd1);
        check("ovf_snap", {16'd0, dg_b}, 32'h9990);
        repeat (8) cyc(1, 0, 0, 0);
        check("model_full", m_count[1], 9999);
        check("ovf_running_pre", {31'd0, run_b}, 32'd1);
        check("ovf_flag_pre", {31'd0, ovf_b}, 32'd0);
        cyc(1, 0, 0, 0);
        check("ovf_flag", {31'd0, ovf_b}, 32'd1);
        check("ovf_running", {31'd0, run_b}, 32'd0);
        check("ovf_frozen", {31'd0, frz_b}, 32'd0);
        check("ovf_digits", {16'd0, dg_b}, 32'h9999);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check("ovf_ignore", {16'd0, dg_b}, 32'h9999);
        check("ovf_ignore_flag", {31'd0, ovf_b}, 32'd1);
        check("ovf_ignore_frz", {31'd0, frz_b}, 32'd0);
        cyc(1, 0, 0, 1);
        check("ovf_clear_digits", {16'd0, dg_b}, 32'h0);
        check("ovf_clear_flag", {31'd0, ovf_b}, 32'd0);

        // lap freeze
        cyc(1, 1, 0, 0);
        repeat (25) cyc(1, 0, 0, 0);
        check("lap_pre", {16'd0, dg_b}, 32'h0025);
        cyc(1, 0, 1, 0);
        check("lap_frozen", {31'd0, frz_b}, 32'd1);
        for (int c = 0; c < 13; c++) begin
            cyc(1, 0, 0, 0);
            check("lap_hold", {16'd0, dg_b}, 32'h0025);
        end
        check("model_live", m_count[1], 39);
        cyc(1, 0, 1, 0);
        check("lap_release", {16'd0, dg_b}, 32'h0040);
        check("lap_unfrozen", {31'd0, frz_b}, 32'd0);

        // simultaneous pulses
        cyc(1, 1, 0, 1);
        check("sim_clr_digits", {16'd0, dg_b}, 32'h0);
        check("sim_clr_running", {31'd0, run_b}, 32'd0);
        cyc(1, 1, 1, 0);
        check("sim_ss_lap_run", {31'd0, run_b}, 32'd1);
        check("sim_ss_lap_frz", {31'd0, frz_b}, 32'd0);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        check("sim_pause_run", {31'd0, run_b}, 32'd0);
        check("sim_pause_frz", {31'd0, frz_b}, 32'd1);
        cyc(1, 0, 0, 1);

        // randomized pulses on both instances
        for (int c = 0; c < 3000; c++) begin
            cycle2($urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(63) == 0,
                   $urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(63) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
